// File: rtl/uart_pkg.sv
// Shared read-FSM state type and word-size constant for the UART receive buffer.
package uart_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_DATA,
    DONE
  } rd_state_e;

  function automatic logic [1:0] last_byte_idx(input logic word_mode);
    return word_mode ? 2'(WORD_BYTES - 1) : 2'd0;
  endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO with extra-bit pointers; count is derived from the registered pointers.
module uart_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   push,
  input  logic [7:0]             push_data,
  input  logic                   pop,
  output logic [7:0]             pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE    = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        push_ok, pop_ok;

  assign count    = wr_ptr_q - rd_ptr_q;
  assign full     = (count == FULL_COUNT);
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign pop_ok   = pop & ~empty;
  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign push_ok  = push & (~full | pop_ok);
  assign pop_data = mem[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_rx_buffer.sv
// UART receive buffer: filters received bytes into a FIFO and serves byte/word
// read requests from the core with a one-cycle completion pulse.
module uart_rx_buffer
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   rx_ready,
  input  logic [7:0]             rx_data,
  input  logic                   rx_ferr,
  input  logic                   rd_go,
  input  logic                   rd_word,
  output logic [31:0]            rd_data,
  output logic                   rd_done,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   ferr_seen,
  input  logic                   clr_err
);
  rd_state_e   state_q;
  logic        word_q;
  logic [1:0]  idx_q;
  logic [31:0] rd_data_q;
  logic        rd_done_q;
  logic        overflow_q, overflow_d;
  logic        ferr_q, ferr_d;
  logic        push, pop, full, empty;
  logic [7:0]  pop_data;

  assign pop  = (state_q == WAIT_DATA) & ~empty;
  assign push = rx_ready & ~rx_ferr & (~full | pop);

  uart_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push),
    .push_data (rx_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  // Setting wins over clr_err when both happen in one cycle.
  always_comb begin
    overflow_d = (overflow_q & ~clr_err) | (rx_ready & ~rx_ferr & full & ~pop);
    ferr_d     = (ferr_q & ~clr_err) | (rx_ready & rx_ferr);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow_q <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
      ferr_q     <= ferr_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      word_q    <= 1'b0;
      idx_q     <= 2'd0;
      rd_data_q <= '0;
      rd_done_q <= 1'b0;
    end else begin
      rd_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rd_go) begin
            state_q   <= WAIT_DATA;
            word_q    <= rd_word;
            idx_q     <= 2'd0;
            rd_data_q <= '0;
          end
        end
        WAIT_DATA: begin
          if (pop) begin
            for (int b = 0; b < WORD_BYTES; b++) begin
              if (idx_q == 2'(b)) rd_data_q[8*b +: 8] <= pop_data;
            end
            idx_q <= idx_q + 2'd1;
            if (idx_q == last_byte_idx(word_q)) begin
              state_q   <= DONE;
              rd_done_q <= 1'b1;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_done   = rd_done_q;
  assign overflow  = overflow_q;
  assign ferr_seen = ferr_q;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Self-checking bench for uart_rx_buffer: directed scenarios plus random traffic
// compared against a queue-based model of the buffer and read protocol.
module tb_uart_rx_buffer;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rstn;
  logic        rx_ready, rx_ferr, rd_go, rd_word, clr_err;
  logic [7:0]  rx_data;
  logic [31:0] rd_data;
  logic        rd_done, overflow, ferr_seen;
  logic [4:0]  count;

  always #5 clk = ~clk;

  uart_rx_buffer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .rx_ready  (rx_ready),
    .rx_data   (rx_data),
    .rx_ferr   (rx_ferr),
    .rd_go     (rd_go),
    .rd_word   (rd_word),
    .rd_data   (rd_data),
    .rd_done   (rd_done),
    .count     (count),
    .overflow  (overflow),
    .ferr_seen (ferr_seen),
    .clr_err   (clr_err)
  );

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  // Model: FIFO contents as a queue, a pending read as bytes still needed.
  logic [7:0]  mq[$];
  bit          m_ovf, m_ferr, m_busy, m_done, m_word;
  int          m_need, m_got;
  logic [31:0] m_acc, m_result;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 0; m_ferr = 0; m_busy = 0; m_done = 0; m_word = 0;
    m_need = 0; m_got = 0; m_acc = '0; m_result = '0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_count"},    {27'b0, count},     32'd0);
    check({tag, "_rd_done"},  {31'b0, rd_done},   32'd0);
    check({tag, "_rd_data"},  rd_data,            32'd0);
    check({tag, "_overflow"}, {31'b0, overflow},  32'd0);
    check({tag, "_ferr"},     {31'b0, ferr_seen}, 32'd0);
  endtask

  // One clock cycle of stimulus; model advanced, then every output compared.
  task automatic cycle(input bit rdy, input logic [7:0] d, input bit fe,
                       input bit go, input bit wd, input bit clr);
    bit accept;
    bit fin;
    rx_ready = rdy; rx_data = d; rx_ferr = fe; rd_go = go; rd_word = wd; clr_err = clr;
    accept = go && !m_busy && !m_done;
    fin = 0;
    if (m_busy && mq.size() > 0) begin
      m_acc = m_acc | ({24'b0, mq.pop_front()} << (8 * m_got));
      m_got++;
      if (m_got == m_need) begin
        fin = 1; m_busy = 0; m_result = m_acc;
      end
    end
    if (clr) begin m_ovf = 0; m_ferr = 0; end
    if (rdy && fe) m_ferr = 1;
    else if (rdy) begin
      if (mq.size() < DEPTH) mq.push_back(d);
      else m_ovf = 1;
    end
    if (accept) begin
      m_busy = 1; m_word = wd; m_need = wd ? 4 : 1; m_got = 0; m_acc = '0;
    end
    m_done = fin;
    @(posedge clk);
    #1;
    rx_ready = 0; rx_ferr = 0; rd_go = 0; rd_word = 0; clr_err = 0;
    if (rd_done === 1'b1) done_seen++;
    check("rd_done",   {31'b0, rd_done},   {31'b0, m_done});
    check("count",     {27'b0, count},     32'(mq.size()));
    check("overflow",  {31'b0, overflow},  {31'b0, m_ovf});
    check("ferr_seen", {31'b0, ferr_seen}, {31'b0, m_ferr});
    if (!m_busy) check("rd_data", rd_data, m_result);
    if (m_done) $display("read done mode=%s data=%h count=%0d",
                         m_word ? "word" : "byte", rd_data, count);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 8'h00, 0, 0, 0, 0);
  endtask

  task automatic read_word();
    cycle(0, 8'h00, 0, 1, 1, 0);
    idle(5);
  endtask

  logic [7:0] pushed [17];
  int         done_base;

  initial begin
    rstn = 0; rx_ready = 0; rx_data = '0; rx_ferr = 0;
    rd_go = 0; rd_word = 0; clr_err = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rstn = 1;
    idle(2);

    // Byte read: done two cycles after rd_go.
    cycle(1, 8'h41, 0, 0, 0, 0);
    cycle(0, 8'h00, 0, 1, 0, 0);
    check("byte_lat1", {31'b0, rd_done}, 32'd0);
    idle(1);
    check("byte_done", {31'b0, rd_done}, 32'd1);
    check("byte_data", rd_data, 32'h0000_0041);
    check("byte_count", {27'b0, count}, 32'd0);
    idle(3);
    check("byte_hold", rd_data, 32'h0000_0041);

    // Word read: done five cycles after rd_go, little-endian.
    cycle(1, 8'h78, 0, 0, 0, 0);
    cycle(1, 8'h56, 0, 0, 0, 0);
    cycle(1, 8'h34, 0, 0, 0, 0);
    cycle(1, 8'h12, 0, 0, 0, 0);
    cycle(0, 8'h00, 0, 1, 1, 0);
    idle(3);
    check("word_lat4", {31'b0, rd_done}, 32'd0);
    idle(1);
    check("word_done", {31'b0, rd_done}, 32'd1);
    check("word_data", rd_data, 32'h1234_5678);
    idle(2);

    // Word read on empty FIFO with slow arrivals.
    done_base = done_seen;
    cycle(0, 8'h00, 0, 1, 1, 0);
    for (int b = 1; b <= 4; b++) begin
      idle(99);
      cycle(1, 8'(b), 0, 0, 0, 0);
    end
    idle(3);
    check("slow_single_done", 32'(done_seen - done_base), 32'd1);
    check("slow_data", rd_data, 32'h0403_0201);

    // Overflow: 17 pushes into 16 slots.
    for (int i = 0; i < 17; i++) begin
      pushed[i] = 8'($urandom);
      cycle(1, pushed[i], 0, 0, 0, 0);
    end
    check("ovf_count", {27'b0, count}, 32'd16);
    check("ovf_flag", {31'b0, overflow}, 32'd1);
    cycle(1, 8'hEE, 0, 0, 0, 1);
    check("ovf_set_beats_clr", {31'b0, overflow}, 32'd1);
    cycle(0, 8'h00, 0, 0, 0, 1);
    check("ovf_cleared", {31'b0, overflow}, 32'd0);
    for (int w = 0; w < 4; w++) read_word();
    check("ovf_last_word", rd_data, {pushed[15], pushed[14], pushed[13], pushed[12]});
    check("ovf_drained", {27'b0, count}, 32'd0);

    // Framing error discards the byte.
    cycle(1, 8'h33, 0, 0, 0, 0);
    cycle(1, 8'hFF, 1, 0, 0, 0);
    check("ferr_count", {27'b0, count}, 32'd1);
    check("ferr_flag", {31'b0, ferr_seen}, 32'd1);
    cycle(0, 8'h00, 0, 1, 0, 0);
    idle(2);
    check("ferr_byte", rd_data, 32'h0000_0033);

    // Push into a full FIFO in the same cycle as a pop.
    for (int i = 0; i < 16; i++) cycle(1, 8'(i + 8'h80), 0, 0, 0, 0);
    cycle(0, 8'h00, 0, 1, 0, 0);
    cycle(1, 8'hA5, 0, 0, 0, 0);
    check("full_pop_count", {27'b0, count}, 32'd16);
    check("full_pop_noovf", {31'b0, overflow}, 32'd0);
    check("full_pop_data", rd_data, 32'h0000_0080);
    idle(1);
    for (int w = 0; w < 4; w++) read_word();
    check("full_pop_tail", rd_data[31:24], 32'h0000_00A5);

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      cycle($urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 7) == 0,
            $urandom_range(0, 5) == 0, 1'($urandom), $urandom_range(0, 19) == 0);
    end

    // Reset in the middle of a word read after two pops.
    rstn = 0;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rstn = 1;
    for (int i = 0; i < 4; i++) cycle(1, 8'(8'hC0 + i), 0, 0, 0, 0);
    cycle(0, 8'h00, 0, 1, 1, 0);
    idle(2);
    check("mid_read_count", {27'b0, count}, 32'd2);
    done_base = done_seen;
    #2;
    rstn = 0;
    #1;
    check_zero("async_reset");
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("held_reset");
    rstn = 1;
    idle(10);
    check("reset_no_done", 32'(done_seen - done_base), 32'd0);
    check("reset_empty", {27'b0, count}, 32'd0);

    // Normal service resumes after reset.
    cycle(1, 8'h5A, 0, 0, 0, 0);
    cycle(0, 8'h00, 0, 1, 0, 0);
    idle(2);
    check("post_reset_data", rd_data, 32'h0000_005A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_buffer.md
UART_RX_BUFFER -- requirements
Module: uart_rx_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, byte FIFO capacity (power of two, >= 4).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port rx_ready  input  1  one-cycle pulse from byte receiver, rx_data valid.
REQ-005 SHALL have port rx_data  input  8  received byte, qualified by rx_ready.
REQ-006 SHALL have port rx_ferr  input  1  framing error, qualified by rx_ready.
REQ-007 SHALL have port rd_go  input  1  one-cycle read request from core.
REQ-008 SHALL have port rd_word  input  1  sampled with rd_go: 1 = 32-bit word (4 bytes), 0 = one byte.
REQ-009 SHALL have port rd_data  output  32  read result.
REQ-010 SHALL have port rd_done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port count  output  $clog2(DEPTH)+1  bytes currently held.
REQ-012 SHALL have port overflow  output  1  sticky: byte dropped because FIFO full.
REQ-013 SHALL have port ferr_seen  output  1  sticky: byte discarded on framing error.
REQ-014 SHALL have port clr_err  input  1  clears overflow and ferr_seen.

Function
REQ-015 SHALL push rx_data when rx_ready=1, rx_ferr=0, and FIFO not full or a pop occurs in the same cycle.
REQ-016 SHALL discard the byte and set ferr_seen when rx_ready=1 and rx_ferr=1.
REQ-017 SHALL discard the byte and set overflow when rx_ready=1, rx_ferr=0, count==DEPTH and no pop that cycle.
REQ-018 SHALL, on simultaneous push and pop, perform both; count unchanged; pointers wrap modulo DEPTH.
REQ-019 SHALL give set priority over clr_err when both occur in the same cycle.
REQ-020 SHALL implement FSM states IDLE, WAIT_DATA, DONE.
REQ-021 SHALL go IDLE -> WAIT_DATA on rd_go, latching rd_word into mode and clearing byte index to 0.
REQ-022 SHALL ignore rd_go in any state other than IDLE.
REQ-023 SHALL, in WAIT_DATA, pop one byte per cycle while count!=0, writing byte index i to rd_data[8i+7:8i].
REQ-024 SHALL in byte mode zero rd_data[31:8]; in word mode store bytes little-endian (first-received byte in [7:0]).
REQ-025 SHALL go WAIT_DATA -> DONE in the cycle after the last required byte (1 or 4) is popped; WAIT_DATA holds indefinitely while empty.
REQ-026 SHALL assert rd_done=1 in DONE only, then go DONE -> IDLE unconditionally.
REQ-027 SHALL hold rd_data stable from DONE until the next accepted rd_go.
REQ-028 SHALL give minimum latency rd_go (cycle 0) -> rd_done of 2 cycles in byte mode and 5 cycles in word mode, when data present.
REQ-029 SHALL allow a byte pushed in cycle N to be popped no earlier than cycle N+1.
REQ-030 SHALL drive count combinationally from registered pointers, never exceeding DEPTH.

Reset
REQ-031 SHALL on rstn=0 immediately force state IDLE, pointers 0, count 0, rd_data 0, rd_done 0, overflow 0, ferr_seen 0.
REQ-032 SHALL abandon a read in progress on reset with no rd_done pulse; partially popped bytes are lost.
REQ-033 SHALL not require FIFO storage contents to be reset.

Structure
REQ-034 SHALL place the FSM state typedef and WORD_BYTES=4 in shared package uart_pkg.
REQ-035 SHALL implement storage/pointers in one sub-module uart_byte_fifo (push, pop, full, empty, count).
REQ-036 SHALL keep all core-facing handshake logic in uart_rx_buffer.

Verification
REQ-037 SHALL cover: push 0x41, rd_go with rd_word=0 -> rd_done 2 cycles later, rd_data=0x00000041, count 0.
REQ-038 SHALL cover: push 0x78,0x56,0x34,0x12, rd_go with rd_word=1 -> rd_done 5 cycles later, rd_data=0x12345678.
REQ-039 SHALL cover: rd_go with rd_word=1 on empty FIFO, bytes 0x01..0x04 arriving 100 cycles apart -> single rd_done, rd_data=0x04030201.
REQ-040 SHALL cover: DEPTH=16, push 17 bytes with no reads -> count=16, overflow=1, 17th byte absent; clr_err -> overflow=0.
REQ-041 SHALL cover: rx_ready with rx_ferr=1, data 0xFF -> count unchanged, ferr_seen=1; push while full concurrent with pop -> accepted.
REQ-042 SHALL cover: rstn low during word read after 2 pops -> no rd_done, all outputs 0, FIFO empty after release.
